galaxy_loader: RTL and testbench
================================

# galaxy_loader

Download router between the HPS ioctl stream and the two loadable stores. It takes the single sequential byte stream from the OSD file load. The first `IMG_BYTES` bytes are the VFD artwork and go to SDRAM through a request/acknowledge write port. The next `ROM_BYTES` bytes go to the ucom43 program ROM injection port. The block back-pressures the HPS with `ioctl_wait` and reports completion and stream errors to the top level, which holds the MCU and VFD in reset until `done`.

## Interface
Parameters:
- `IMG_BYTES`, 614400 — artwork bytes (2 × 640 × 480) routed to SDRAM.
- `ROM_BYTES`, 4096 — program bytes routed to the ROM port.

Ports:
- `clk` in 1 — system clock (`clk_sys`, 100 MHz); the only clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `ioctl_download` in 1 — download window active.
- `ioctl_wr` in 1 — one-cycle byte strobe.
- `ioctl_addr` in 25 — byte address of the strobed byte.
- `ioctl_dout` in 8 — byte data.
- `ioctl_wait` out 1 — stall request to the HPS.
- `sdram_addr` out 25 — artwork write address.
- `sdram_din` out 8 — artwork write data.
- `sdram_we` out 1 — write request, level.
- `sdram_ack` in 1 — one-cycle write-complete pulse.
- `rom_we` out 1 — one-cycle ROM write strobe.
- `rom_addr` out 12 — ROM byte address.
- `rom_data` out 8 — ROM byte data.
- `loading` out 1 — high from download start until FINISH.
- `done` out 1 — sticky: last download was complete and clean.
- `error` out 1 — sticky: last download had a fault.

## Operation
- Byte counter `cnt` is 25 bits. It clears on the rising edge of `ioctl_download`, which also clears `done` and `error`.
- States:
  - IDLE: waits for a download.
  - ARMED: download active, no byte pending.
  - SDRAM: write request outstanding.
  - ROM: single-cycle ROM write.
  - FINISH: evaluate and report.
- IDLE → ARMED on `ioctl_download` rising.
- ARMED, on `ioctl_wr`:
  - Capture address and data; check `ioctl_addr == cnt`. A mismatch sets `error`, but the byte is still routed by `cnt`.
  - `cnt < IMG_BYTES` → SDRAM, with `sdram_addr = cnt`.
  - `IMG_BYTES ≤ cnt < IMG_BYTES + ROM_BYTES` → ROM, with `rom_addr = cnt − IMG_BYTES`, truncated to 12 bits.
  - Otherwise: drop the byte, set `error`, stay in ARMED.
- SDRAM: hold `sdram_we`, `sdram_addr` and `sdram_din` stable until `sdram_ack`. Then `cnt += 1` and go to ARMED.
- ROM: `rom_we` high for exactly one cycle, then `cnt += 1` and go to ARMED.
- ARMED → FINISH when `ioctl_download` is low. FINISH → IDLE after one cycle.
- In FINISH, `done = ~error & (cnt == IMG_BYTES + ROM_BYTES)`. If `cnt` differs, `error` is set instead.
- `ioctl_download` falling while in SDRAM or ROM: the pending write completes first, then the FSM goes to FINISH.
- `ioctl_wr` while in SDRAM or ROM is a protocol violation: set `error` and drop the byte.
- Reset mid-operation: the pending write is abandoned and `sdram_we` drops immediately (asynchronously).

## Timing
- Reset values: all outputs 0; FSM in IDLE; `cnt` = 0.
- `ioctl_wait` is registered. It rises in the cycle after an accepted `ioctl_wr` and stays high for the whole SDRAM or ROM state. It falls in the cycle after `sdram_ack` or after the `rom_we` cycle.
- ROM byte: `rom_we` is asserted 1 cycle after `ioctl_wr`, and `ioctl_wait` is high for 1 cycle.
- SDRAM byte: `sdram_we` is asserted 1 cycle after `ioctl_wr`. It deasserts in the same clock edge that samples `sdram_ack`; there is no timeout.
- `sdram_ack` outside the SDRAM state is ignored.
- `loading` rises 1 cycle after `ioctl_download` rises and falls as the FSM leaves FINISH.
- `done` and `error` update on the FINISH cycle and hold until the next download starts or reset.

## Structure
- Shared package `galaxy_pkg`:
  - state enum `loader_state_t`
  - `IMG_BYTES_DEF = 614400`
  - `ROM_BYTES_DEF = 4096`
  - `LOAD_BYTES = IMG_BYTES_DEF + ROM_BYTES_DEF`
- Single module. No sub-module is needed; the routing compare lives inline.

## Test plan
- Full clean load: 618496 sequential bytes, `sdram_ack` 3 cycles after each request.
  - Expect 614400 SDRAM writes with addresses 0..614399.
  - Expect 4096 `rom_we` pulses, with byte 614400 at `rom_addr` 0 and byte 618495 at `rom_addr` 4095.
  - Expect `done` = 1 and `error` = 0.
- Boundary byte: `cnt` = 614399 goes to SDRAM; the next byte produces `rom_we` with `rom_addr` = 0 and no SDRAM request.
- Overflow: 618497 bytes → the last byte is dropped with no write; `error` = 1, `done` = 0.
- Short load: download ends after 1000 bytes → `error` = 1, `done` = 0, `loading` = 0 two cycles later.
- Protocol faults:
  - `ioctl_wr` while in SDRAM waiting for ack → byte dropped, `error` = 1, the original write still completes.
  - `ioctl_addr` = 5 when `cnt` = 4 → `error` = 1.
- Reset mid-write: deassert `reset_n` while `sdram_we` is high → `sdram_we`, `ioctl_wait` and `loading` drop to 0 asynchronously; the FSM returns to IDLE.

Source files
------------

// File: rtl/galaxy_pkg.sv
// Shared types and sizing constants for the galaxy download router.
package galaxy_pkg;

    localparam int unsigned CNT_W         = 25;
    localparam int unsigned ROM_AW        = 12;
    localparam int unsigned IMG_BYTES_DEF = 614400;
    localparam int unsigned ROM_BYTES_DEF = 4096;
    localparam int unsigned LOAD_BYTES    = IMG_BYTES_DEF + ROM_BYTES_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SDRAM,
        ST_ROM,
        ST_FINISH
    } loader_state_t;

endpackage

// File: rtl/galaxy_loader.sv
// Routes the ioctl byte stream: artwork to the SDRAM write port, program bytes
// to the ROM injection port, with HPS back-pressure and completion reporting.
module galaxy_loader
    import galaxy_pkg::*;
#(
    parameter int unsigned IMG_BYTES = IMG_BYTES_DEF,
    parameter int unsigned ROM_BYTES = ROM_BYTES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [CNT_W-1:0]    ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                ioctl_wait,
    output logic [CNT_W-1:0]    sdram_addr,
    output logic [7:0]          sdram_din,
    output logic                sdram_we,
    input  logic                sdram_ack,
    output logic                rom_we,
    output logic [ROM_AW-1:0]   rom_addr,
    output logic [7:0]          rom_data,
    output logic                loading,
    output logic                done,
    output logic                error
);

    localparam logic [CNT_W-1:0] IMG_END  = CNT_W'(IMG_BYTES);
    localparam logic [CNT_W-1:0] LOAD_END = CNT_W'(IMG_BYTES + ROM_BYTES);

    loader_state_t    state;
    loader_state_t    state_next;
    logic             download_q;
    logic             download_rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             error_next;
    logic             done_next;
    logic             take_sdram;
    logic             take_rom;

    assign download_rise = ioctl_download & ~download_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, byte routing and status decisions.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        error_next = error;
        done_next  = done;
        take_sdram = 1'b0;
        take_rom   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (download_rise) begin
                    state_next = ST_ARMED;
                    cnt_next   = '0;
                    error_next = 1'b0;
                    done_next  = 1'b0;
                end
            end
            ST_ARMED: begin
                if (ioctl_wr) begin
                    // Misaddressed bytes are flagged but still routed by count.
                    if (ioctl_addr != cnt) begin
                        error_next = 1'b1;
                    end
                    if (cnt < IMG_END) begin
                        take_sdram = 1'b1;
                        state_next = ST_SDRAM;
                    end else if (cnt < LOAD_END) begin
                        take_rom   = 1'b1;
                        state_next = ST_ROM;
                    end else begin
                        error_next = 1'b1;
                    end
                end else if (!ioctl_download) begin
                    state_next = ST_FINISH;
                end
            end
            ST_SDRAM: begin
                if (ioctl_wr) begin
                    error_next = 1'b1;
                end
                if (sdram_ack) begin
                    cnt_next   = cnt + CNT_W'(1);
                    state_next = ST_ARMED;
                end
            end
            ST_ROM: begin
                if (ioctl_wr) begin
                    error_next = 1'b1;
                end
                cnt_next   = cnt + CNT_W'(1);
                state_next = ST_ARMED;
            end
            ST_FINISH: begin
                if (cnt == LOAD_END) begin
                    done_next = ~error;
                end else begin
                    done_next  = 1'b0;
                    error_next = 1'b1;
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered datapath and outputs; reset abandons any pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            download_q <= 1'b0;
            cnt        <= '0;
            error      <= 1'b0;
            done       <= 1'b0;
            sdram_we   <= 1'b0;
            ioctl_wait <= 1'b0;
            rom_we     <= 1'b0;
            loading    <= 1'b0;
            sdram_addr <= '0;
            sdram_din  <= '0;
            rom_addr   <= '0;
            rom_data   <= '0;
        end else begin
            download_q <= ioctl_download;
            cnt        <= cnt_next;
            error      <= error_next;
            done       <= done_next;
            sdram_we   <= (state_next == ST_SDRAM);
            rom_we     <= (state_next == ST_ROM);
            ioctl_wait <= (state_next == ST_SDRAM) || (state_next == ST_ROM);
            loading    <= (state_next != ST_IDLE);
            if (take_sdram) begin
                sdram_addr <= cnt;
                sdram_din  <= ioctl_dout;
            end
            if (take_rom) begin
                rom_addr <= ROM_AW'(cnt - IMG_END);
                rom_data <= ioctl_dout;
            end
        end
    end

endmodule

// File: tb/tb_galaxy_loader.sv
// Directed bench for galaxy_loader using a scaled-down image/ROM split.
module tb_galaxy_loader;

    localparam int unsigned IMG  = 16;
    localparam int unsigned ROM  = 8;
    localparam int unsigned LOAD = IMG + ROM;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [24:0] sdram_addr;
    logic [7:0]  sdram_din;
    logic        sdram_we;
    logic        sdram_ack;
    logic        rom_we;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        loading;
    logic        done;
    logic        error;

    int vectors      = 0;
    int miscompares  = 0;
    int sdram_writes = 0;
    int rom_writes   = 0;
    int wcnt         = 0;
    bit ack_en       = 1'b1;

    galaxy_loader #(.IMG_BYTES(IMG), .ROM_BYTES(ROM)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .sdram_addr     (sdram_addr),
        .sdram_din      (sdram_din),
        .sdram_we       (sdram_we),
        .sdram_ack      (sdram_ack),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .loading        (loading),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte strobe from a negedge; returns on the first negedge with ioctl_wait low.
    task automatic send_byte(input int a, input int d);
        int k;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = 8'(d);
        @(negedge clk);
        ioctl_wr = 1'b0;
        k = 0;
        while (ioctl_wait && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("wait_release", 32'(ioctl_wait), 32'd0);
    endtask

    task automatic begin_load();
        sdram_writes = 0;
        rom_writes   = 0;
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_load();
        ioctl_download = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // SDRAM responder (ack three cycles after request) and write monitors.
    initial begin
        sdram_ack = 1'b0;
        forever begin
            @(negedge clk);
            sdram_ack = 1'b0;
            if (sdram_we && ack_en) begin
                wcnt++;
                if (wcnt == 3) begin
                    check("sdram_addr", 32'(sdram_addr), 32'(sdram_writes));
                    check("sdram_din", 32'(sdram_din), 32'(pat(sdram_writes)));
                    sdram_writes++;
                    sdram_ack = 1'b1;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
            if (rom_we) begin
                check("rom_addr", 32'(rom_addr), 32'(rom_writes));
                check("rom_data", 32'(rom_data), 32'(pat(IMG + rom_writes)));
                check("rom_excl_sdram", 32'(sdram_we), 32'd0);
                rom_writes++;
            end
        end
    end

    initial begin
        reset_n        = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        #3 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_sdram_we", 32'(sdram_we), 32'd0);
        check("rst_rom_we", 32'(rom_we), 32'd0);
        check("rst_loading", 32'(loading), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Full clean load with cycle-level check of the image/ROM boundary.
        ioctl_download = 1'b1;
        check("loading_pre", 32'(loading), 32'd0);
        sdram_writes = 0;
        rom_writes   = 0;
        @(negedge clk);
        check("loading_rise", 32'(loading), 32'd1);
        for (int i = 0; i < int'(IMG); i++) send_byte(i, pat(i));
        check("boundary_sdram_cnt", 32'(sdram_writes), 32'(IMG));
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(IMG);
        ioctl_dout = pat(IMG);
        @(negedge clk);
        ioctl_wr = 1'b0;
        check("bnd_rom_we", 32'(rom_we), 32'd1);
        check("bnd_rom_addr", 32'(rom_addr), 32'd0);
        check("bnd_sdram_we", 32'(sdram_we), 32'd0);
        check("bnd_wait_hi", 32'(ioctl_wait), 32'd1);
        @(negedge clk);
        check("bnd_rom_we_off", 32'(rom_we), 32'd0);
        check("bnd_wait_lo", 32'(ioctl_wait), 32'd0);
        for (int i = int'(IMG) + 1; i < int'(LOAD); i++) send_byte(i, pat(i));
        ioctl_download = 1'b0;
        @(negedge clk);
        check("full_loading_finish", 32'(loading), 32'd1);
        @(negedge clk);
        check("full_loading_off", 32'(loading), 32'd0);
        check("full_done", 32'(done), 32'd1);
        check("full_error", 32'(error), 32'd0);
        check("full_sdram_cnt", 32'(sdram_writes), 32'(IMG));
        check("full_rom_cnt", 32'(rom_writes), 32'(ROM));

        // Overflow: one byte past the end is dropped; done clears on new start.
        begin_load();
        check("ovf_done_cleared", 32'(done), 32'd0);
        for (int i = 0; i < int'(LOAD) + 1; i++) send_byte(i, pat(i));
        end_load();
        check("ovf_sdram_cnt", 32'(sdram_writes), 32'(IMG));
        check("ovf_rom_cnt", 32'(rom_writes), 32'(ROM));
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_done", 32'(done), 32'd0);

        // Short load.
        begin_load();
        for (int i = 0; i < 10; i++) send_byte(i, pat(i));
        ioctl_download = 1'b0;
        @(negedge clk);
        check("short_loading_1", 32'(loading), 32'd1);
        @(negedge clk);
        check("short_loading_2", 32'(loading), 32'd0);
        check("short_error", 32'(error), 32'd1);
        check("short_done", 32'(done), 32'd0);

        // Strobe during an outstanding SDRAM write.
        begin_load();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd0;
        ioctl_dout = pat(0);
        @(negedge clk);
        check("pv_sdram_we", 32'(sdram_we), 32'd1);
        check("pv_wait", 32'(ioctl_wait), 32'd1);
        ioctl_addr = 25'd1;
        ioctl_dout = 8'hAA;
        @(negedge clk);
        ioctl_wr = 1'b0;
        check("pv_din_held", 32'(sdram_din), 32'(pat(0)));
        check("pv_we_held", 32'(sdram_we), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("pv_we_dropped", 32'(sdram_we), 32'd0);
        check("pv_wait_dropped", 32'(ioctl_wait), 32'd0);
        check("pv_writes", 32'(sdram_writes), 32'd1);
        end_load();
        check("pv_error", 32'(error), 32'd1);
        check("pv_done", 32'(done), 32'd0);

        // Address mismatch: byte at cnt 4 tagged as address 5.
        begin_load();
        for (int i = 0; i < 4; i++) send_byte(i, pat(i));
        check("am_error_before", 32'(error), 32'd0);
        send_byte(5, pat(4));
        end_load();
        check("am_writes", 32'(sdram_writes), 32'd5);
        check("am_error", 32'(error), 32'd1);
        check("am_done", 32'(done), 32'd0);

        // Reset during an outstanding SDRAM write.
        ack_en = 1'b0;
        begin_load();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd0;
        ioctl_dout = pat(0);
        @(negedge clk);
        ioctl_wr = 1'b0;
        check("rmw_we_before", 32'(sdram_we), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rmw_we_async", 32'(sdram_we), 32'd0);
        check("rmw_wait_async", 32'(ioctl_wait), 32'd0);
        check("rmw_loading_async", 32'(loading), 32'd0);
        ioctl_download = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ack_en  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rmw_idle_loading", 32'(loading), 32'd0);
        check("rmw_idle_we", 32'(sdram_we), 32'd0);

        // Clean load after reset recovers.
        begin_load();
        for (int i = 0; i < int'(LOAD); i++) send_byte(i, pat(i));
        end_load();
        check("rec_done", 32'(done), 32'd1);
        check("rec_error", 32'(error), 32'd0);
        check("rec_rom_cnt", 32'(rom_writes), 32'(ROM));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
